// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: shifts out NUM_BYTES bytes (byte 0 first, LSB first) with
// optional parity, one or two stop bits, an idle gap after each frame and a beacon repeat mode.
module uart_frame_tx #(
    parameter int CLKFREQ     = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int NUM_BYTES   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FRAME_GAP   = 0,
    parameter int AUTO_REPEAT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] frame_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   byte_done,
    output logic                   frame_done,
    output logic                   UART_tx
);

    localparam int BAUD_DIV   = CLKFREQ / BAUD;
    localparam int CNT_W      = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam bit HAS_PARITY = (PARITY != 0);
    localparam bit HAS_GAP    = (FRAME_GAP > 0);
    localparam bit REPEAT     = (AUTO_REPEAT != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       baud_q;
    logic [2:0]             bit_q;
    logic                   stop_q;
    logic [7:0]             gap_q;
    logic [IDX_W-1:0]       idx_q;
    logic [8*NUM_BYTES-1:0] shadow_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   byte_done_q;
    logic                   frame_done_q;

    logic                   baud_last_s;
    logic                   baud_pre_s;
    logic                   last_stop_s;
    logic                   last_byte_s;
    logic                   last_gap_s;
    logic                   byte_end_s;
    logic                   frame_end_s;
    logic [7:0]             cur_byte_s;

    function automatic logic parity_bit(input logic [7:0] d);
        parity_bit = (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // The byte in flight always sits in the low byte of the shadow; it is shifted down per byte.
    assign cur_byte_s  = shadow_q[7:0];
    assign baud_last_s = (baud_q == CNT_W'(BAUD_DIV - 1));
    assign baud_pre_s  = (baud_q == CNT_W'(BAUD_DIV - 2));
    assign last_stop_s = (stop_q == 1'(STOP_BITS - 1));
    assign last_byte_s = (idx_q == IDX_W'(NUM_BYTES - 1));
    assign last_gap_s  = (gap_q == 8'(FRAME_GAP - 1));

    // Decode which bit slot closes a byte or the whole frame.
    always_comb begin
        byte_end_s  = 1'b0;
        frame_end_s = 1'b0;
        case (state_q)
            ST_STOP: begin
                byte_end_s  = last_stop_s;
                frame_end_s = last_stop_s && last_byte_s && !HAS_GAP;
            end
            ST_GAP: begin
                byte_end_s  = 1'b0;
                frame_end_s = last_gap_s;
            end
            default: begin
                byte_end_s  = 1'b0;
                frame_end_s = 1'b0;
            end
        endcase
    end

    // Transmit FSM; outputs are set one clock ahead so they appear from flops in the right slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            stop_q       <= 1'b0;
            gap_q        <= 8'd0;
            idx_q        <= '0;
            shadow_q     <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            byte_done_q  <= byte_end_s && baud_pre_s;
            frame_done_q <= frame_end_s && baud_pre_s;
            if (state_q == ST_IDLE) begin
                baud_q <= '0;
                if (start) begin
                    shadow_q <= frame_data;
                    idx_q    <= '0;
                    state_q  <= ST_START;
                    tx_q     <= 1'b0;
                    busy_q   <= 1'b1;
                end
            end else if (!baud_last_s) begin
                baud_q <= baud_q + CNT_W'(1);
            end else begin
                baud_q <= '0;
                if (frame_end_s) begin
                    if (REPEAT) begin
                        shadow_q <= frame_data;
                        idx_q    <= '0;
                        state_q  <= ST_START;
                        tx_q     <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end
                end else begin
                    case (state_q)
                        ST_START: begin
                            state_q <= ST_DATA;
                            bit_q   <= 3'd0;
                            tx_q    <= cur_byte_s[0];
                        end
                        ST_DATA: begin
                            if (bit_q == 3'd7) begin
                                stop_q <= 1'b0;
                                if (HAS_PARITY) begin
                                    state_q <= ST_PARITY;
                                    tx_q    <= parity_bit(cur_byte_s);
                                end else begin
                                    state_q <= ST_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= cur_byte_s[bit_q + 3'd1];
                            end
                        end
                        ST_PARITY: begin
                            state_q <= ST_STOP;
                            stop_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end
                        ST_STOP: begin
                            if (!last_stop_s) begin
                                stop_q <= stop_q + 1'b1;
                            end else if (!last_byte_s) begin
                                idx_q    <= idx_q + IDX_W'(1);
                                shadow_q <= shadow_q >> 8;
                                state_q  <= ST_START;
                                tx_q     <= 1'b0;
                            end else begin
                                state_q <= ST_GAP;
                                gap_q   <= 8'd0;
                                tx_q    <= 1'b1;
                            end
                        end
                        ST_GAP: begin
                            gap_q <= gap_q + 8'd1;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign UART_tx    = tx_q;
    assign busy       = busy_q;
    assign byte_done  = byte_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: six parameterisations, a mid-bit sampling receiver
// model and pulse/cycle monitors; expected values are hand-computed constants.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  st;
    logic [63:0] fd_a;
    logic [7:0]  fd_b, fd_c, fd_d, fd_f;
    logic [31:0] fd_e;
    wire  [5:0]  tx_w, busy_w, bd_w, fdn_w;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int bd_cnt [6];
    int fd_cnt [6];
    int bd_at  [6];
    int fd_at  [6];
    int f_idle = 0;
    int c0, bd0, fc0, f0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_tx u_a (.clk(clk), .rst(rst), .frame_data(fd_a), .start(st[0]), .busy(busy_w[0]),
                       .byte_done(bd_w[0]), .frame_done(fdn_w[0]), .UART_tx(tx_w[0]));
    uart_frame_tx #(.NUM_BYTES(1), .PARITY(2)) u_b (.clk(clk), .rst(rst), .frame_data(fd_b), .start(st[1]),
                       .busy(busy_w[1]), .byte_done(bd_w[1]), .frame_done(fdn_w[1]), .UART_tx(tx_w[1]));
    uart_frame_tx #(.NUM_BYTES(1), .PARITY(1)) u_c (.clk(clk), .rst(rst), .frame_data(fd_c), .start(st[2]),
                       .busy(busy_w[2]), .byte_done(bd_w[2]), .frame_done(fdn_w[2]), .UART_tx(tx_w[2]));
    uart_frame_tx #(.NUM_BYTES(1), .STOP_BITS(2)) u_d (.clk(clk), .rst(rst), .frame_data(fd_d), .start(st[3]),
                       .busy(busy_w[3]), .byte_done(bd_w[3]), .frame_done(fdn_w[3]), .UART_tx(tx_w[3]));
    uart_frame_tx #(.CLKFREQ(1000), .BAUD(100), .NUM_BYTES(4)) u_e (.clk(clk), .rst(rst), .frame_data(fd_e),
                       .start(st[4]), .busy(busy_w[4]), .byte_done(bd_w[4]), .frame_done(fdn_w[4]), .UART_tx(tx_w[4]));
    uart_frame_tx #(.NUM_BYTES(1), .FRAME_GAP(2), .AUTO_REPEAT(1)) u_f (.clk(clk), .rst(rst), .frame_data(fd_f),
                       .start(st[5]), .busy(busy_w[5]), .byte_done(bd_w[5]), .frame_done(fdn_w[5]), .UART_tx(tx_w[5]));

    // Pulse monitor: at each rising edge record the pulses of the clock that just ended.
    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (bd_w[i] === 1'b1) begin
                bd_cnt[i] <= bd_cnt[i] + 1;
                bd_at[i]  <= cyc;
            end
            if (fdn_w[i] === 1'b1) begin
                fd_cnt[i] <= fd_cnt[i] + 1;
                fd_at[i]  <= cyc;
            end
        end
        if (busy_w[5] !== 1'b1) f_idle <= f_idle + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: entered on the falling edge of clock 0 of a start bit, samples every
    // bit in its middle and returns on the falling edge of clock 0 of the following bit slot.
    task automatic rx_byte(input int inst, input int div, input int npar, input int nstop,
                           output logic sb, output logic [7:0] d, output logic pb, output logic [1:0] sp);
        d  = 8'h00;
        pb = 1'b0;
        sp = 2'b00;
        repeat (div / 2) @(negedge clk);
        sb = tx_w[inst];
        for (int b = 0; b < 8; b++) begin
            repeat (div) @(negedge clk);
            d[b] = tx_w[inst];
        end
        if (npar != 0) begin
            repeat (div) @(negedge clk);
            pb = tx_w[inst];
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (div) @(negedge clk);
            sp[s] = tx_w[inst];
        end
        repeat (div - div / 2) @(negedge clk);
    endtask

    task automatic rx_chk(input string tag, input int inst, input int div, input int npar, input int nstop,
                          input logic [7:0] exp_d, input logic exp_p);
        logic       sb;
        logic [7:0] d;
        logic       pb;
        logic [1:0] sp;
        rx_byte(inst, div, npar, nstop, sb, d, pb, sp);
        chk({tag, "_startbit"}, 32'(sb), 32'd0);
        chk({tag, "_data"}, 32'(d), 32'(exp_d));
        if (npar != 0) chk({tag, "_parity"}, 32'(pb), 32'(exp_p));
        chk({tag, "_stop"}, 32'(sp), (nstop == 2) ? 32'd3 : 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        st   = 6'd0;
        fd_a = 64'd0; fd_b = 8'd0; fd_c = 8'd0; fd_d = 8'd0; fd_e = 32'd0; fd_f = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_w), 32'h3F);
        chk("rst_busy", 32'(busy_w), 32'h0);
        chk("rst_byte_done", 32'(bd_w), 32'h0);
        chk("rst_frame_done", 32'(fdn_w), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Default 8-byte frame
        fd_a  = 64'h8776_6554_4332_2110;
        st[0] = 1'b1;
        chk("t1_idle_tx", 32'(tx_w[0]), 32'd1);
        chk("t1_idle_busy", 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        st[0] = 1'b0;
        c0 = cyc; bd0 = bd_cnt[0]; fc0 = fd_cnt[0];
        chk("t1_startbit_now", 32'(tx_w[0]), 32'd0);
        chk("t1_busy_now", 32'(busy_w[0]), 32'd1);
        for (int k = 0; k < 8; k++) rx_chk($sformatf("t1_b%0d", k), 0, 434, 0, 1, 8'(16 + 17 * k), 1'b0);
        chk("t1_busy_after", 32'(busy_w[0]), 32'd0);
        chk("t1_tx_after", 32'(tx_w[0]), 32'd1);
        chk("t1_byte_done_cnt", 32'(bd_cnt[0] - bd0), 32'd8);
        chk("t1_frame_done_cnt", 32'(fd_cnt[0] - fc0), 32'd1);
        chk("t1_frame_done_at", 32'(fd_at[0] - c0), 32'd34719);
        chk("t1_last_bd_with_fd", 32'(bd_at[0] - c0), 32'd34719);

        // Even and odd parity on 21h
        fd_b = 8'h21; st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0; c0 = cyc;
        chk("t2e_startbit_now", 32'(tx_w[1]), 32'd0);
        rx_chk("t2e", 1, 434, 1, 1, 8'h21, 1'b0);
        chk("t2e_frame_done_at", 32'(fd_at[1] - c0), 32'd4773);
        chk("t2e_busy_after", 32'(busy_w[1]), 32'd0);
        fd_c = 8'h21; st[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0; c0 = cyc;
        rx_chk("t2o", 2, 434, 1, 1, 8'h21, 1'b1);
        chk("t2o_frame_done_at", 32'(fd_at[2] - c0), 32'd4773);
        chk("t2o_busy_after", 32'(busy_w[2]), 32'd0);

        // Two stop bits on A5h
        fd_d = 8'hA5; st[3] = 1'b1;
        @(negedge clk);
        st[3] = 1'b0; c0 = cyc;
        rx_chk("t3", 3, 434, 0, 2, 8'hA5, 1'b0);
        chk("t3_byte_done_at", 32'(bd_at[3] - c0), 32'd4773);
        chk("t3_frame_done_at", 32'(fd_at[3] - c0), 32'd4773);
        chk("t3_busy_after", 32'(busy_w[3]), 32'd0);

        // Beacon mode with a two-bit gap
        fd_f = 8'h5A; st[5] = 1'b1;
        @(negedge clk);
        st[5] = 1'b0; c0 = cyc; f0 = f_idle;
        rx_chk("t5_f1", 5, 434, 0, 1, 8'h5A, 1'b0);
        chk("t5_gap_tx", 32'(tx_w[5]), 32'd1);
        chk("t5_gap_busy", 32'(busy_w[5]), 32'd1);
        fd_f = 8'h96;
        repeat (434) @(negedge clk);
        chk("t5_gap2_tx", 32'(tx_w[5]), 32'd1);
        repeat (433) @(negedge clk);
        chk("t5_last_gap_tx", 32'(tx_w[5]), 32'd1);
        chk("t5_frame_done_pulse", 32'(fdn_w[5]), 32'd1);
        @(negedge clk);
        chk("t5_restart_tx", 32'(tx_w[5]), 32'd0);
        chk("t5_frame_done_at", 32'(fd_at[5] - c0), 32'd5207);
        rx_chk("t5_f2", 5, 434, 0, 1, 8'h96, 1'b0);
        chk("t5_busy_never_low", 32'(f_idle - f0), 32'd0);

        // Start and data changes while busy are ignored; back-to-back restart
        fd_e = 32'h015A_C33C; st[4] = 1'b1;
        @(negedge clk);
        st[4] = 1'b0; c0 = cyc; bd0 = bd_cnt[4]; fc0 = fd_cnt[4];
        rx_chk("t4_b0", 4, 10, 0, 1, 8'h3C, 1'b0);
        fd_e = 32'h0FF0_AA42; st[4] = 1'b1;
        rx_chk("t4_b1", 4, 10, 0, 1, 8'hC3, 1'b0);
        st[4] = 1'b0;
        rx_chk("t4_b2", 4, 10, 0, 1, 8'h5A, 1'b0);
        rx_chk("t4_b3", 4, 10, 0, 1, 8'h01, 1'b0);
        chk("t4_idle_busy", 32'(busy_w[4]), 32'd0);
        chk("t4_idle_tx", 32'(tx_w[4]), 32'd1);
        chk("t4_byte_done_cnt", 32'(bd_cnt[4] - bd0), 32'd4);
        chk("t4_frame_done_cnt", 32'(fd_cnt[4] - fc0), 32'd1);
        chk("t4_frame_done_at", 32'(fd_at[4] - c0), 32'd399);
        st[4] = 1'b1;
        @(negedge clk);
        st[4] = 1'b0;
        chk("t4_b2b_startbit", 32'(tx_w[4]), 32'd0);
        chk("t4_b2b_busy", 32'(busy_w[4]), 32'd1);

        // Asynchronous reset in the middle of a low data bit
        repeat (13) @(negedge clk);
        chk("t6_databit_low", 32'(tx_w[4]), 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_async_tx", 32'(tx_w[4]), 32'd1);
        chk("t6_async_busy", 32'(busy_w[4]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fd_e = 32'h1234_5678; st[4] = 1'b1;
        chk("t6_idle_tx", 32'(tx_w[4]), 32'd1);
        @(negedge clk);
        st[4] = 1'b0;
        chk("t6_startbit", 32'(tx_w[4]), 32'd0);
        rx_chk("t6_b0", 4, 10, 0, 1, 8'h78, 1'b0);
        rx_chk("t6_b1", 4, 10, 0, 1, 8'h56, 1'b0);
        rx_chk("t6_b2", 4, 10, 0, 1, 8'h34, 1'b0);
        rx_chk("t6_b3", 4, 10, 0, 1, 8'h12, 1'b0);
        chk("t6_busy_after", 32'(busy_w[4]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
